// File: rtl/fringe_window_sequencer_if.sv
// rtl/fringe_window_sequencer_if.sv - window handshake, fringe strobes and result bus of the fringe sequencer
interface fringe_window_sequencer_if #(
    parameter int pCntW = 10
);
    logic             iWinValid;
    logic             oWinReady;
    logic             oDataValid;
    logic             oEn;
    logic             iDecision;
    logic             oResValid;
    logic             oResBorder;
    logic [pCntW-1:0] ovResCol;
    logic [pCntW-1:0] ovResRow;

    modport master (
        output iWinValid, iDecision,
        input  oWinReady, oDataValid, oEn, oResValid, oResBorder, ovResCol, ovResRow
    );

    modport slave (
        input  iWinValid, iDecision,
        output oWinReady, oDataValid, oEn, oResValid, oResBorder, ovResCol, ovResRow
    );
endinterface

// File: rtl/fringe_window_sequencer.sv
// rtl/fringe_window_sequencer.sv - raster sequencer, border bypass and noisy-pixel counter for the fringe stage
module fringe_window_sequencer #(
    parameter int pWidth  = 512,
    parameter int pHeight = 512,
    parameter int pCntW   = 10
) (
    input  logic                   iClk,
    input  logic                   iRst,
    input  logic                   iStart,
    fringe_window_sequencer_if.slave win,
    output logic [2*pCntW-1:0]     ovNoisyCnt,
    output logic                   oBusy,
    output logic                   oFrameDone
);
    localparam logic [pCntW-1:0]   LastCol  = pCntW'(pWidth - 1);
    localparam logic [pCntW-1:0]   LastRow  = pCntW'(pHeight - 1);
    localparam logic [2*pCntW-1:0] NoisyMax = {(2*pCntW){1'b1}};

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               drain_q;
    logic [pCntW-1:0]   col_q, row_q;
    logic               s1_valid_q, s1_border_q;
    logic [pCntW-1:0]   s1_col_q, s1_row_q;
    logic               s2_valid_q, s2_border_q;
    logic [pCntW-1:0]   s2_col_q, s2_row_q;
    logic [2*pCntW-1:0] noisy_q;
    logic               frame_done_q;

    logic accept;
    logic clear_frame;
    logic last_pix;
    logic border;

    // Next state, handshake and fringe strobes
    always_comb begin
        state_d        = state_q;
        accept         = win.iWinValid && (state_q == S_RUN);
        clear_frame    = iStart && (state_q == S_IDLE);
        last_pix       = (col_q == LastCol) && (row_q == LastRow);
        border         = (row_q == '0) || (row_q == LastRow) ||
                         (col_q == '0) || (col_q == LastCol);
        win.oWinReady  = (state_q == S_RUN);
        win.oDataValid = accept;
        win.oEn        = s1_valid_q && !s1_border_q;
        win.oResValid  = s2_valid_q;
        win.oResBorder = s2_border_q;
        win.ovResCol   = s2_col_q;
        win.ovResRow   = s2_row_q;
        ovNoisyCnt     = noisy_q;
        oBusy          = (state_q != S_IDLE);
        oFrameDone     = frame_done_q;
        case (state_q)
            S_IDLE:  if (clear_frame) state_d = S_RUN;
            S_RUN:   if (accept && last_pix) state_d = S_DRAIN;
            S_DRAIN: if (drain_q) state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register; drain_q counts the two cycles needed to empty both pipe stages
    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= S_IDLE;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            drain_q <= (state_q == S_DRAIN) ? ~drain_q : 1'b0;
        end
    end

    // Raster position of the next window; row holds at the last line so it never wraps
    always_ff @(posedge iClk) begin
        if (iRst || clear_frame) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == LastCol) begin
                col_q <= '0;
                if (row_q != LastRow) row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    // Two-stage coordinate pipe matching the fringe stage latch and output register
    always_ff @(posedge iClk) begin
        if (iRst) begin
            s1_valid_q  <= 1'b0;
            s1_border_q <= 1'b0;
            s1_col_q    <= '0;
            s1_row_q    <= '0;
            s2_valid_q  <= 1'b0;
            s2_border_q <= 1'b0;
            s2_col_q    <= '0;
            s2_row_q    <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_border_q <= border;
                s1_col_q    <= col_q;
                s1_row_q    <= row_q;
            end
            s2_valid_q  <= s1_valid_q;
            s2_border_q <= s1_border_q;
            s2_col_q    <= s1_col_q;
            s2_row_q    <= s1_row_q;
        end
    end

    // Saturating noisy count of interior results; frame-done is registered so it follows the final count update
    always_ff @(posedge iClk) begin
        if (iRst) begin
            noisy_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= (state_q == S_DONE);
            if (clear_frame) begin
                noisy_q <= '0;
            end else if (s2_valid_q && !s2_border_q && win.iDecision && (noisy_q != NoisyMax)) begin
                noisy_q <= noisy_q + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fringe_window_sequencer.sv
// tb/tb_fringe_window_sequencer.sv - randomized self-checking bench for fringe_window_sequencer
module tb_fringe_window_sequencer;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int CW   = 4;
    localparam int NW   = 2 * CW;
    localparam int MAXC = 4096;

    logic          iClk = 1'b0;
    logic          iRst = 1'b1;
    logic          iStart = 1'b0;
    logic [NW-1:0] ovNoisyCnt;
    logic          oBusy;
    logic          oFrameDone;

    fringe_window_sequencer_if #(.pCntW(CW)) win();

    fringe_window_sequencer #(.pWidth(W), .pHeight(H), .pCntW(CW)) dut (
        .iClk       (iClk),
        .iRst       (iRst),
        .iStart     (iStart),
        .win        (win),
        .ovNoisyCnt (ovNoisyCnt),
        .oBusy      (oBusy),
        .oFrameDone (oFrameDone)
    );

    always #5 iClk = ~iClk;

    int errors = 0;
    int checks = 0;

    // Reference model: frame progress as a pixel index plus a timeline of expected events per cycle
    int cyc = 0;
    bit m_run = 0;
    bit m_frame_end = 0;
    int m_idx = 0;
    int m_busy_until = 0;
    int m_noisy = 0;
    bit en_e[MAXC];
    bit rv_e[MAXC];
    bit rb_e[MAXC];
    bit done_e[MAXC];
    int rc_e[MAXC];
    int rr_e[MAXC];
    bit cur_v, cur_s, cur_d, cur_r;

    function automatic bit m_busy();
        return m_run || (cyc < m_busy_until);
    endfunction

    task automatic apply(input bit v, input bit s, input bit d, input bit r);
        cur_v = v; cur_s = s; cur_d = d; cur_r = r;
        win.iWinValid = v;
        iStart        = s;
        win.iDecision = d;
        iRst          = r;
        @(negedge iClk);
    endtask

    task automatic advance();
        int r, c;
        bit b;
        @(posedge iClk);
        if (cur_r) begin
            m_run = 0; m_frame_end = 0; m_busy_until = 0; m_noisy = 0;
            for (int k = cyc + 1; k < cyc + 8 && k < MAXC; k++) begin
                en_e[k] = 0; rv_e[k] = 0; done_e[k] = 0;
            end
        end else begin
            if (rv_e[cyc] && !rb_e[cyc] && cur_d && m_noisy < (1 << NW) - 1) m_noisy++;
            if (m_run && cur_v) begin
                r = m_idx / W;
                c = m_idx % W;
                b = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
                en_e[cyc + 1] = !b;
                rv_e[cyc + 2] = 1;
                rb_e[cyc + 2] = b;
                rc_e[cyc + 2] = c;
                rr_e[cyc + 2] = r;
                m_idx++;
                if (m_idx == W * H) begin
                    m_run = 0;
                    m_frame_end = 1;
                    m_busy_until = cyc + 4;
                    done_e[cyc + 4] = 1;
                end
            end else if (!m_busy() && cur_s) begin
                m_run = 1; m_idx = 0; m_noisy = 0; m_frame_end = 0;
            end
        end
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        apply(0, 0, 0, 1);
        advance();
        apply(0, 0, 0, 0);
        checks++;
        if ({win.oWinReady, win.oDataValid, win.oEn, win.oResValid, win.oResBorder, oBusy, oFrameDone} !== 7'b0) begin
            errors++; $display("FAIL reset_strobes: got %b want 0000000",
                {win.oWinReady, win.oDataValid, win.oEn, win.oResValid, win.oResBorder, oBusy, oFrameDone});
        end
        checks++;
        if ({win.ovResCol, win.ovResRow, ovNoisyCnt} !== '0) begin
            errors++; $display("FAIL reset_values: col %0d row %0d noisy %0d want all 0", win.ovResCol, win.ovResRow, ovNoisyCnt);
        end
        advance();
    endtask

    // One full frame; vmode 0=back-to-back 1=alternating 2=random, dmode 0=zero 1=one 2=random
    task automatic test_frame(input string name, input int vmode, input int dmode, input bit mid_start);
        int k = 0;
        int n_rv = 0, n_en = 0, n_done = 0;
        bit finished = 0;
        bit v, d, s;
        while (!finished && k < 300) begin
            v = (vmode == 0) ? 1'b1 : (vmode == 1) ? ((k % 2) == 1) : 1'($urandom_range(0, 1));
            d = (dmode == 0) ? 1'b0 : (dmode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
            s = (k == 0) || (mid_start && (k == 4 || k == 7));
            apply(v, s, d, 0);
            checks++;
            if (win.oWinReady !== m_run) begin
                errors++; $display("FAIL %s ready cyc %0d: got %b want %b", name, cyc, win.oWinReady, m_run);
            end
            checks++;
            if (win.oDataValid !== (m_run && v)) begin
                errors++; $display("FAIL %s data_valid cyc %0d: got %b want %b", name, cyc, win.oDataValid, m_run && v);
            end
            checks++;
            if (win.oEn !== en_e[cyc]) begin
                errors++; $display("FAIL %s en cyc %0d: got %b want %b", name, cyc, win.oEn, en_e[cyc]);
            end
            checks++;
            if (win.oResValid !== rv_e[cyc]) begin
                errors++; $display("FAIL %s res_valid cyc %0d: got %b want %b", name, cyc, win.oResValid, rv_e[cyc]);
            end
            if (rv_e[cyc]) begin
                checks++;
                if (win.oResBorder !== rb_e[cyc] || win.ovResCol !== CW'(rc_e[cyc]) || win.ovResRow !== CW'(rr_e[cyc])) begin
                    errors++; $display("FAIL %s result cyc %0d: got b%b (%0d,%0d) want b%b (%0d,%0d)", name, cyc,
                        win.oResBorder, win.ovResRow, win.ovResCol, rb_e[cyc], rr_e[cyc], rc_e[cyc]);
                end
            end
            checks++;
            if (ovNoisyCnt !== NW'(m_noisy)) begin
                errors++; $display("FAIL %s noisy cyc %0d: got %0d want %0d", name, cyc, ovNoisyCnt, m_noisy);
            end
            checks++;
            if (oBusy !== m_busy() || oFrameDone !== done_e[cyc]) begin
                errors++; $display("FAIL %s busy_done cyc %0d: got %b%b want %b%b", name, cyc, oBusy, oFrameDone, m_busy(), done_e[cyc]);
            end
            n_rv   += int'(win.oResValid);
            n_en   += int'(win.oEn);
            n_done += int'(oFrameDone);
            finished = m_frame_end && (cyc == m_busy_until);
            advance();
            k++;
        end
        checks++;
        if (!finished) begin
            errors++; $display("FAIL %s timeout: frame end not reached in %0d cycles", name, k);
        end
        checks++;
        if (n_rv != W * H || n_en != (W - 2) * (H - 2) || n_done != 1) begin
            errors++; $display("FAIL %s totals: res %0d en %0d done %0d want %0d %0d 1", name, n_rv, n_en, n_done, W * H, (W - 2) * (H - 2));
        end
        if (dmode == 1) begin
            checks++;
            if (ovNoisyCnt !== NW'((W - 2) * (H - 2))) begin
                errors++; $display("FAIL %s noisy_total: got %0d want %0d", name, ovNoisyCnt, (W - 2) * (H - 2));
            end
        end
        for (int j = 0; j < 3; j++) begin
            apply(1'($urandom_range(0, 1)), 0, 1, 0);
            checks++;
            if (ovNoisyCnt !== NW'(m_noisy) || oBusy !== 1'b0 || win.oWinReady !== 1'b0) begin
                errors++; $display("FAIL %s idle_hold: noisy %0d busy %b ready %b want %0d 0 0", name, ovNoisyCnt, oBusy, win.oWinReady, m_noisy);
            end
            advance();
        end
    endtask

    task automatic test_reset_midframe();
        apply(0, 1, 0, 0);
        advance();
        for (int j = 0; j < 5; j++) begin
            apply(1, 0, 1, 0);
            advance();
        end
        apply(0, 0, 0, 1);
        advance();
        apply(0, 0, 0, 0);
        checks++;
        if ({win.oWinReady, win.oDataValid, win.oEn, win.oResValid, win.oResBorder, oBusy, oFrameDone} !== 7'b0 ||
            {win.ovResCol, win.ovResRow, ovNoisyCnt} !== '0) begin
            errors++; $display("FAIL midframe_reset: strobes %b col %0d row %0d noisy %0d want all 0",
                {win.oWinReady, win.oDataValid, win.oEn, win.oResValid, win.oResBorder, oBusy, oFrameDone},
                win.ovResCol, win.ovResRow, ovNoisyCnt);
        end
        advance();
    endtask

    task automatic test_idle_block();
        for (int j = 0; j < 4; j++) begin
            apply(1, 0, 1, 0);
            checks++;
            if (win.oWinReady !== 1'b0 || win.oDataValid !== 1'b0 || win.oResValid !== 1'b0 || ovNoisyCnt !== NW'(m_noisy)) begin
                errors++; $display("FAIL idle_block: ready %b dv %b rv %b noisy %0d want 0 0 0 %0d",
                    win.oWinReady, win.oDataValid, win.oResValid, ovNoisyCnt, m_noisy);
            end
            advance();
        end
    endtask

    initial begin
        win.iWinValid = 1'b0;
        win.iDecision = 1'b0;
        @(posedge iClk);
        #1;
        test_reset();
        test_frame("back_to_back", 0, 0, 0);
        test_frame("noisy_all", 0, 1, 0);
        test_idle_block();
        test_frame("bubbles", 1, 2, 0);
        test_frame("start_in_run", 2, 2, 1);
        test_frame("noisy_again", 2, 1, 0);
        test_reset_midframe();
        test_frame("after_reset", 2, 2, 0);
        test_idle_block();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
